fixed_point_divider: RTL and testbench
======================================

Name: fixed_point_divider

Overview:
- Signed fixed-point divider: C = A / B, with N-bit two's-complement operands and Q fractional bits.
- Inverse operation of the team's fixed-point multiplier. Used where datapath values must be normalised or scaled back; sits beside the multiplier in the arithmetic library.
- Sequential restoring division, one quotient bit per clock, with a start/busy/done handshake.
- Quotient is truncated toward zero. Overflow and divide-by-zero saturate and are flagged.

Parameters:
- Q, 1, number of fractional bits in A, B and C.
- N, 16, total word width of A, B and C, sign bit included.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active high.
- start  input  1  request; sampled only in IDLE.
- A  input  N  dividend, signed Q-format; sampled with start.
- B  input  N  divisor, signed Q-format; sampled with start.
- busy  output  1  high from the edge accepting start until the edge that asserts done.
- done  output  1  one-cycle pulse; C and the flags are valid from this cycle.
- C  output  N  quotient, signed Q-format; holds its value until the next done.
- ovf  output  1  quotient saturated; updated with done, held.
- div_by_zero  output  1  B was 0; updated with done, held.

Behaviour:
- Reset: state=IDLE; busy, done, C, ovf, div_by_zero all 0; internal registers cleared. Reset mid-operation aborts the division with no done pulse.
- States:
  - IDLE -> DIVIDE on start with B!=0.
  - IDLE -> FINISH on start with B==0.
  - DIVIDE -> FINISH after N+Q iterations.
  - FINISH -> IDLE unconditionally.
- On accept (edge k):
  - neg = A[N-1] ^ B[N-1].
  - magA = |A|, magB = |B|, as N-bit unsigned; two's-complement negate when the sign bit is set. 2^(N-1) is representable unsigned.
  - Dividend register = magA << Q (N+Q bits). Remainder = 0 (N+1 bits). Iteration counter = 0. busy=1.
- DIVIDE, each edge:
  - Shift the next dividend MSB into the remainder.
  - If remainder >= magB: subtract magB and shift in quotient bit 1; else shift in 0.
  - The last iteration completes at edge k+N+Q.
- Quotient register width is N+Q bits; the unsigned magnitude q is exact and truncated toward zero.
- FINISH (edge k+N+Q+1; edge k+1 for divide-by-zero): load C and flags, done=1, busy=0.
- Result rules:
  - Divide-by-zero: C = 0x7FFF..F if A>=0, else 0x800..0; div_by_zero=1, ovf=0.
  - Not neg, q > 2^(N-1)-1: C = 0x7FFF..F, ovf=1.
  - neg, q > 2^(N-1): C = 0x800..0, ovf=1.
  - neg, q == 2^(N-1): C = 0x800..0, ovf=0 (exact).
  - Otherwise: C = neg ? -q : q (low N bits), ovf=0.
  - A==0 with B!=0: C=0, regardless of sign of B (no -0).
- Latency: done is high for the single cycle after edge k+N+Q+1 (edge k+1 for divide-by-zero). A new start may be accepted in the cycle done is high, since the state is already IDLE.
- start while busy is ignored; no queueing.
- A and B may change freely after the accepting edge.

Test Plan (N=16, Q=1):
- Basic: A=6 (3.0), B=4 (2.0), start one cycle -> done exactly 18 edges later; C=3 (1.5), ovf=0, div_by_zero=0; busy high for 18 cycles.
- Sign combinations: A=0xFFFA/B=4 -> C=0xFFFD; A=6/B=0xFFFC -> C=0xFFFD; A=0xFFFA/B=0xFFFC -> C=3.
- Truncation toward zero: A=7/B=4 -> C=3 (1.5); A=0xFFF9/B=4 -> C=0xFFFD (-1.5).
- Saturation boundaries:
  - A=0x7FFF, B=1 -> C=0x7FFF, ovf=1.
  - A=0x8000, B=1 -> C=0x8000, ovf=1.
  - A=0x8000, B=2 -> C=0x8000, ovf=0 (exact -2^15).
  - A=0, B=0xFFFC -> C=0.
- Divide-by-zero: A=10/B=0 -> done at the second edge after start, C=0x7FFF, div_by_zero=1; A=0xFFF6/B=0 -> C=0x8000, div_by_zero=1.
- Handshake/reset:
  - start pulsed again mid-division -> ignored, one done only.
  - start held high continuously -> back-to-back results every 19 cycles.
  - rst asserted at iteration 8 -> all outputs 0 immediately, no done; the next division is correct.

Source files
------------

// File: rtl/fixed_point_divider_if.sv
// Handshake bundle for the sequential fixed-point divider.
// The requester drives start/A/B; the divider returns C and its status flags.
interface fixed_point_divider_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] C;
  logic         ovf;
  logic         div_by_zero;

  modport master (output start, A, B, input busy, done, C, ovf, div_by_zero);
  modport slave  (input start, A, B, output busy, done, C, ovf, div_by_zero);
endinterface

// File: rtl/fixed_point_divider.sv
// Signed Q-format divider C = A / B: restoring division on magnitudes, one quotient bit
// per clock, truncation toward zero, saturation with ovf and div_by_zero flags.
module fixed_point_divider #(
  parameter int Q = 1,
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fixed_point_divider_if.slave  dif
);
  localparam int W  = N + Q;
  localparam int CW = $clog2(W + 1);
  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};
  localparam logic [W-1:0] HALF = {{Q{1'b0}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   dq_q, dq_d;       // dividend bits shift out the top, quotient bits shift in
  logic [N:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   magb_q, magb_d;
  logic           neg_q, neg_d, aneg_q, aneg_d, dbz_q, dbz_d;
  logic           busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dbzo_q, dbzo_d;
  logic [N-1:0]   c_q, c_d;

  logic [N-1:0]   mag_a, mag_b;
  logic [N:0]     rem_sh, rem_sub;
  logic           ge;

  assign mag_a   = dif.A[N-1] ? -dif.A : dif.A;
  assign mag_b   = dif.B[N-1] ? -dif.B : dif.B;
  assign rem_sh  = {rem_q[N-1:0], dq_q[W-1]};
  assign rem_sub = rem_sh - {1'b0, magb_q};
  assign ge      = rem_sh >= {1'b0, magb_q};

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    magb_d  = magb_q;
    neg_d   = neg_q;
    aneg_d  = aneg_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dbzo_d  = dbzo_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (dif.start) begin
          neg_d   = dif.A[N-1] ^ dif.B[N-1];
          aneg_d  = dif.A[N-1];
          magb_d  = mag_b;
          dq_d    = {mag_a, {Q{1'b0}}};
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          dbz_d   = (dif.B == '0);
          state_d = (dif.B == '0) ? FINISH : DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = ge ? rem_sub : rem_sh;
        dq_d  = {dq_q[W-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbzo_d  = dbz_q;
        ovf_d   = 1'b0;
        if (dbz_q) begin
          c_d = aneg_q ? MINV : MAXV;
        end else if (!neg_q) begin
          ovf_d = dq_q >= HALF;
          c_d   = (dq_q >= HALF) ? MAXV : dq_q[N-1:0];
        end else begin
          // -2^(N-1) is exactly representable, so only strictly larger magnitudes overflow
          ovf_d = dq_q > HALF;
          c_d   = (dq_q >= HALF) ? MINV : -dq_q[N-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dq_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      magb_q  <= '0;
      neg_q   <= 1'b0;
      aneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbzo_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      magb_q  <= magb_d;
      neg_q   <= neg_d;
      aneg_q  <= aneg_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dbzo_q  <= dbzo_d;
      c_q     <= c_d;
    end
  end

  assign dif.busy        = busy_q;
  assign dif.done        = done_q;
  assign dif.C           = c_q;
  assign dif.ovf         = ovf_q;
  assign dif.div_by_zero = dbzo_q;
endmodule

// File: tb/tb_fixed_point_divider.sv
// Randomised and directed checks of fixed_point_divider against an integer-arithmetic model.
module tb_fixed_point_divider;
  localparam int N = 16;
  localparam int Q = 1;
  localparam int LAT = N + Q + 1;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  fixed_point_divider_if #(.N(N)) dif ();
  fixed_point_divider #(.Q(Q), .N(N)) dut (.clk(clk), .rst(rst), .dif(dif));

  // Quotient in Q format is (A * 2^Q) / B with C-style truncation, then clamped to N bits.
  task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] c, output logic ov, output logic dz);
    longint sa, sb, qv, maxv, minv;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    maxv = (longint'(1) << (N - 1)) - 1;
    minv = -(longint'(1) << (N - 1));
    ov = 1'b0;
    dz = 1'b0;
    if (sb == 0) begin
      dz = 1'b1;
      qv = (sa < 0) ? minv : maxv;
    end else begin
      qv = (sa * (longint'(1) << Q)) / sb;
      if (qv > maxv) begin qv = maxv; ov = 1'b1; end
      if (qv < minv) begin qv = minv; ov = 1'b1; end
    end
    c = qv[N-1:0];
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] c, output logic ov, output logic dz,
                       output int lat, output int bcnt, output bit tmo);
    @(negedge clk);
    dif.start = 1'b1; dif.A = a; dif.B = b;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.A = N'($urandom); dif.B = N'($urandom);
    lat = 0; bcnt = 0; tmo = 1'b1;
    if (dif.busy) bcnt++;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (dif.done) begin lat = i; tmo = 1'b0; break; end
      if (dif.busy) bcnt++;
    end
    c = dif.C; ov = dif.ovf; dz = dif.div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; dif.start = 1'b0; dif.A = '0; dif.B = '0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({dif.busy, dif.done, dif.C, dif.ovf, dif.div_by_zero} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: busy=%b done=%b C=%h ovf=%b dbz=%b, want all 0",
               dif.busy, dif.done, dif.C, dif.ovf, dif.div_by_zero);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [N-1:0] c; logic ov, dz; int lat, bc; bit tmo;
    do_op(16'h0006, 16'h0004, c, ov, dz, lat, bc, tmo);
    nvec++;
    if (tmo || lat != LAT) begin nerr++; $display("FAIL basic_latency: got %0d (timeout=%0b), want %0d", lat, tmo, LAT); end
    nvec++;
    if (bc != LAT) begin nerr++; $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, LAT); end
    nvec++;
    if ({c, ov, dz} !== {16'h0003, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL basic_result: C=%h ovf=%b dbz=%b, want C=0003 ovf=0 dbz=0", c, ov, dz);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] ta[12] = '{16'h0006, 16'hFFFA, 16'h0006, 16'hFFFA, 16'h0007, 16'hFFF9,
                             16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h000A, 16'hFFF6};
    logic [N-1:0] tb[12] = '{16'h0004, 16'h0004, 16'hFFFC, 16'hFFFC, 16'h0004, 16'h0004,
                             16'h0001, 16'h0001, 16'h0002, 16'hFFFC, 16'h0000, 16'h0000};
    logic [N-1:0] tc[12] = '{16'h0003, 16'hFFFD, 16'hFFFD, 16'h0003, 16'h0003, 16'hFFFD,
                             16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h8000};
    logic         to[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic         tz[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [N-1:0] c; logic ov, dz; int lat, bc, el; bit tmo;
    for (int i = 0; i < 12; i++) begin
      do_op(ta[i], tb[i], c, ov, dz, lat, bc, tmo);
      el = tz[i] ? 1 : LAT;
      nvec++;
      if (tmo || lat != el || {c, ov, dz} !== {tc[i], to[i], tz[i]}) begin
        nerr++;
        $display("FAIL directed_%0d A=%h B=%h: C=%h ovf=%b dbz=%b lat=%0d, want C=%h ovf=%b dbz=%b lat=%0d",
                 i, ta[i], tb[i], c, ov, dz, lat, tc[i], to[i], tz[i], el);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, c, ec; logic ov, dz, eo, ez; int lat, bc, el; bit tmo;
    for (int i = 0; i < 150; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = N'($urandom_range(1, 3));
        2: a = 16'h8000;
        3: a = 16'h7FFF;
        4: a = '0;
        default: ;
      endcase
      ref_div(a, b, ec, eo, ez);
      do_op(a, b, c, ov, dz, lat, bc, tmo);
      el = (b == '0) ? 1 : LAT;
      nvec++;
      if (tmo || lat != el || {c, ov, dz} !== {ec, eo, ez}) begin
        nerr++;
        $display("FAIL random_%0d A=%h B=%h: C=%h ovf=%b dbz=%b lat=%0d, want C=%h ovf=%b dbz=%b lat=%0d",
                 i, a, b, c, ov, dz, lat, ec, eo, ez, el);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [N-1:0] ec, c1; logic eo, ez; int ndone;
    ref_div(16'h0100, 16'h0003, ec, eo, ez);
    @(negedge clk);
    dif.start = 1'b1; dif.A = 16'h0100; dif.B = 16'h0003;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (5) @(negedge clk);
    dif.start = 1'b1; dif.A = 16'h0001; dif.B = 16'h0001;
    @(negedge clk);
    dif.start = 1'b0;
    ndone = 0; c1 = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (dif.done) begin ndone++; if (ndone == 1) c1 = dif.C; end
    end
    nvec++;
    if (ndone != 1) begin nerr++; $display("FAIL ignore_start_done_count: got %0d, want 1", ndone); end
    nvec++;
    if (c1 !== ec) begin nerr++; $display("FAIL ignore_start_result: C=%h, want %h", c1, ec); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b, ec; logic eo, ez; int ndone;
    a = N'($urandom); b = N'($urandom_range(1, 16'h7FFF));
    ref_div(a, b, ec, eo, ez);
    @(negedge clk);
    dif.start = 1'b1; dif.A = a; dif.B = b;
    @(posedge clk); #1;
    ndone = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (dif.done) begin
        nvec++;
        if (i != LAT + ndone * (LAT + 1) || {dif.C, dif.ovf} !== {ec, eo}) begin
          nerr++;
          $display("FAIL back_to_back_%0d: edge=%0d C=%h ovf=%b, want edge=%0d C=%h ovf=%b",
                   ndone, i, dif.C, dif.ovf, LAT + ndone * (LAT + 1), ec, eo);
        end
        ndone++;
        a = N'($urandom); b = N'($urandom_range(1, 16'hFFFF));
        ref_div(a, b, ec, eo, ez);
        dif.A = a; dif.B = b;
      end
    end
    dif.start = 1'b0;
    nvec++;
    if (ndone != 3) begin nerr++; $display("FAIL back_to_back_count: got %0d, want 3", ndone); end
    repeat (25) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] c; logic ov, dz; int lat, bc, ndone; bit tmo;
    do_op(16'h0006, 16'h0004, c, ov, dz, lat, bc, tmo);
    @(negedge clk);
    dif.start = 1'b1; dif.A = 16'h0123; dif.B = 16'h0007;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    nvec++;
    if ({dif.busy, dif.done, dif.C, dif.ovf, dif.div_by_zero} !== '0) begin
      nerr++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b C=%h ovf=%b dbz=%b, want all 0",
               dif.busy, dif.done, dif.C, dif.ovf, dif.div_by_zero);
    end
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (dif.done) ndone++;
    end
    nvec++;
    if (ndone != 0) begin nerr++; $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", ndone); end
    do_op(16'hFFFA, 16'h0004, c, ov, dz, lat, bc, tmo);
    nvec++;
    if (tmo || lat != LAT || {c, ov, dz} !== {16'hFFFD, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_mid_next_op: C=%h ovf=%b dbz=%b lat=%0d, want C=FFFD ovf=0 dbz=0 lat=%0d",
               c, ov, dz, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
